// File: rtl/cp0_exc.sv
// cp0_exc: coprocessor 0 holding SR/Cause/EPC/PRId/Count/Compare and arbitrating
// interrupts against synchronous exceptions for the M-stage pipeline.
module cp0_exc #(
    parameter logic [31:0] PRID    = 32'h0000_4D50,
    parameter logic [31:0] HANDLER = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] din,
    input  logic [31:0] pcM,
    input  logic        bdM,
    input  logic [4:0]  exccodeM,
    input  logic        eretM,
    input  logic [5:0]  hwint,
    output logic [31:0] dout,
    output logic [31:0] epc,
    output logic        intreq,
    output logic [31:0] excpc
);
    logic [5:0]  im_q, ip_q;
    logic        exl_q, ie_q, bd_q, tpend_q;
    logic [4:0]  exccode_q;
    logic [31:0] epc_q, count_q, compare_q;
    logic [5:0]  ip;
    logic        irq, exc, wr;
    logic [31:0] sr, cause, count_d, epc_d;

    assign ip     = {hwint[5] | tpend_q, hwint[4:0]};
    assign irq    = ie_q & ~exl_q & |(ip & im_q);
    assign exc    = (exccodeM != 5'd0) & ~exl_q;
    assign intreq = irq | exc;
    // taking an exception squashes any mtc0 issued alongside it
    assign wr     = we & ~intreq;
    assign sr     = {16'b0, im_q, 8'b0, exl_q, ie_q};
    assign cause  = {bd_q, 15'b0, ip_q, 3'b0, exccode_q, 2'b0};
    assign epc    = epc_q;
    assign excpc  = HANDLER;
    assign count_d = (wr && addr == 5'd9) ? din : count_q + 32'd1;
    assign epc_d   = bdM ? pcM - 32'd4 : pcM;

    always_comb
        dout = addr == 5'd9  ? count_q :
               addr == 5'd11 ? compare_q :
               addr == 5'd12 ? sr :
               addr == 5'd13 ? cause :
               addr == 5'd14 ? epc_q :
               addr == 5'd15 ? PRID : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q      <= '0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            ip_q      <= '0;
            exccode_q <= '0;
            epc_q     <= '0;
            count_q   <= '0;
            compare_q <= 32'hFFFF_FFFF;
            tpend_q   <= 1'b0;
        end else begin
            ip_q    <= ip;
            count_q <= count_d;
            if (count_q == compare_q)
                tpend_q <= 1'b1;
            if (wr && addr == 5'd11) begin
                compare_q <= din;
                tpend_q   <= 1'b0;
            end
            if (intreq) begin
                exl_q     <= 1'b1;
                bd_q      <= bdM;
                exccode_q <= irq ? 5'd0 : exccodeM;
                epc_q     <= {epc_d[31:2], 2'b00};
            end else begin
                if (eretM)
                    exl_q <= 1'b0;
                if (wr && addr == 5'd12) begin
                    im_q  <= din[15:10];
                    exl_q <= din[1];
                    ie_q  <= din[0];
                end
                if (wr && addr == 5'd14)
                    epc_q <= {din[31:2], 2'b00};
            end
        end
    end
endmodule

// File: tb/tb_cp0_exc.sv
// tb_cp0_exc: directed vectors with hand-computed expectations for cp0_exc.
module tb_cp0_exc;
    logic        clk = 1'b0;
    logic        reset, we, bdM, eretM;
    logic [4:0]  addr, exccodeM;
    logic [31:0] din, pcM;
    logic [5:0]  hwint;
    logic [31:0] dout, epc, excpc;
    logic        intreq;
    int total = 0;
    int bad = 0;

    cp0_exc dut (
        .clk(clk), .reset(reset), .we(we), .addr(addr), .din(din),
        .pcM(pcM), .bdM(bdM), .exccodeM(exccodeM), .eretM(eretM),
        .hwint(hwint), .dout(dout), .epc(epc), .intreq(intreq), .excpc(excpc)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] e);
        addr = a;
        #1;
        chk(tag, dout, e);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; din = d;
        tick;
        we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; bdM = 1'b0; eretM = 1'b0;
        addr = '0; exccodeM = '0; din = '0; pcM = '0; hwint = '0;
        tick; tick;
        reset = 1'b0;
        rd("rst_sr", 5'd12, 32'h0);
        rd("rst_cause", 5'd13, 32'h0);
        rd("rst_epc", 5'd14, 32'h0);
        rd("rst_cmp", 5'd11, 32'hFFFF_FFFF);
        rd("rst_prid", 5'd15, 32'h0000_4D50);
        rd("rst_count", 5'd9, 32'h0);
        rd("unused_reg", 5'd3, 32'h0);
        chk("rst_intreq", {31'b0, intreq}, 32'h0);
        chk("excpc", excpc, 32'h0000_4180);

        mtc0(5'd12, 32'h0000_0401);
        rd("sr_write", 5'd12, 32'h0000_0401);
        hwint = 6'b000001; pcM = 32'h3010; bdM = 1'b0;
        #1 chk("irq_req", {31'b0, intreq}, 32'h1);
        tick;
        chk("irq_epc", epc, 32'h3010);
        rd("irq_cause", 5'd13, 32'h0000_0400);
        rd("irq_sr", 5'd12, 32'h0000_0403);
        chk("irq_held_masked", {31'b0, intreq}, 32'h0);

        eretM = 1'b1;
        tick;
        eretM = 1'b0;
        rd("eret_sr", 5'd12, 32'h0000_0401);
        chk("eret_rerequest", {31'b0, intreq}, 32'h1);
        hwint = '0;
        #1 chk("hw_release", {31'b0, intreq}, 32'h0);

        exccodeM = 5'd10; bdM = 1'b1; pcM = 32'h3024;
        #1 chk("exc_req", {31'b0, intreq}, 32'h1);
        tick;
        exccodeM = '0; bdM = 1'b0;
        chk("bd_epc", epc, 32'h3020);
        rd("bd_cause", 5'd13, 32'h8000_0028);
        exccodeM = 5'd4;
        #1 chk("exc_blocked_exl", {31'b0, intreq}, 32'h0);
        exccodeM = '0;

        mtc0(5'd12, 32'h0000_0401);
        rd("sr_exit", 5'd12, 32'h0000_0401);

        hwint = 6'b000001; exccodeM = 5'd4; pcM = 32'h3040;
        we = 1'b1; addr = 5'd14; din = 32'h1234;
        #1 chk("prio_req", {31'b0, intreq}, 32'h1);
        tick;
        we = 1'b0; exccodeM = '0; hwint = '0;
        chk("prio_epc", epc, 32'h3040);
        rd("prio_cause", 5'd13, 32'h0000_0400);

        eretM = 1'b1;
        tick;
        eretM = 1'b0;
        rd("eret2_sr", 5'd12, 32'h0000_0401);
        mtc0(5'd14, 32'h0000_1237);
        chk("epc_write_align", epc, 32'h0000_1234);

        mtc0(5'd11, 32'h0000_0001);
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd9, 32'hFFFF_FFFE);
        rd("cnt_load", 5'd9, 32'hFFFF_FFFE);
        tick;
        rd("cnt_max", 5'd9, 32'hFFFF_FFFF);
        tick;
        rd("cnt_wrap", 5'd9, 32'h0);
        chk("tmr_idle0", {31'b0, intreq}, 32'h0);
        tick;
        chk("tmr_idle1", {31'b0, intreq}, 32'h0);
        tick;
        chk("tmr_req", {31'b0, intreq}, 32'h1);
        tick;
        rd("tmr_cause", 5'd13, 32'h0000_8000);
        rd("tmr_sr", 5'd12, 32'h0000_8003);
        mtc0(5'd11, 32'h0000_0100);
        tick;
        rd("tmr_clear", 5'd13, 32'h0);

        reset = 1'b1;
        tick;
        exccodeM = 5'd5; pcM = 32'h5000;
        #1 chk("rst_exc_req", {31'b0, intreq}, 32'h1);
        tick;
        reset = 1'b0; exccodeM = '0;
        rd("rstwin_epc", 5'd14, 32'h0);
        rd("rstwin_sr", 5'd12, 32'h0);
        rd("rstwin_cause", 5'd13, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cp0_exc.md
# cp0_exc

Coprocessor 0 for the exception-capable pipeline. It sits in the memory stage, directly downstream of the M-stage main decoder, and consumes its `cp0we` strobe and the mtc0/mfc0 operands. It holds the SR, Cause, EPC, PRId, Count and Compare registers and arbitrates interrupts against synchronous exceptions. When an exception or interrupt is taken, it raises `intreq` so the pipeline can flush and redirect to the handler.

## Interface
- `PRID`, 32'h0000_4D50: constant value returned for register 15.
- `HANDLER`, 32'h0000_4180: handler entry address driven on `excpc`.
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `we`, in, 1: mtc0 write enable (`cp0we` from the M-stage decoder).
- `addr`, in, 5: CP0 register number, from instr[15:11], for both read and write.
- `din`, in, 32: mtc0 data (forwarded rt value).
- `pcM`, in, 32: PC of the M-stage instruction.
- `bdM`, in, 1: the M-stage instruction is in a branch delay slot.
- `exccodeM`, in, 5: synchronous exception code; 0 means none.
- `eretM`, in, 1: the M-stage instruction is eret.
- `hwint`, in, 6: external interrupt lines, level-sensitive.
- `dout`, out, 32: mfc0 read data; combinational on `addr`.
- `epc`, out, 32: current EPC, used as the eret target.
- `intreq`, out, 1: take an exception this cycle; combinational.
- `excpc`, out, 32: equals `HANDLER`.

## Operation
- **Register fields**
  - SR(12): IM[15:10], EXL[1], IE[0]. Other bits read as 0.
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2]. Other bits read as 0; Cause is read-only to mtc0.
  - EPC(14): 32 bits, bits [1:0] forced to 0.
  - PRId(15): constant `PRID`.
  - Count(9), Compare(11): 32 bits each.
  - Any other `addr` reads 0.
- **Pending interrupt vector**
  - ip = {hwint[5] | tpend, hwint[4:0]}.
  - tpend is an internal flag: set on the edge where Count == Compare, cleared by an mtc0 to Compare, and cleared by reset.
- **Request logic**
  - irq = IE & ~EXL & |(ip & IM).
  - exc = (exccodeM != 0) & ~EXL.
  - intreq = irq | exc. An interrupt has priority over a synchronous exception.
- **On an edge with intreq = 1**
  - EXL <= 1.
  - BD <= bdM.
  - ExcCode <= irq ? 0 : exccodeM.
  - EPC <= bdM ? pcM-4 : pcM.
  - An mtc0 and an eret in the same cycle are suppressed.
- **Otherwise, on each edge**
  - `eretM` clears EXL.
  - `we` writes the register selected by `addr`: SR (IM/EXL/IE only), EPC, Count or Compare. Writes to other numbers are ignored.
- **Every edge**
  - Cause.IP <= ip.
  - Count <= Count+1, which wraps 32'hFFFF_FFFF -> 0. An mtc0 to Count overrides the increment.
- **State view:** NORMAL (EXL=0) -> HANDLER on intreq. HANDLER -> NORMAL on eret or on an mtc0 that clears SR.EXL. No new request is taken while in HANDLER.

## Timing
- **Reset values**
  - SR = 0, Cause = 0, EPC = 0, Count = 0.
  - Compare = 32'hFFFF_FFFF, tpend = 0.
  - `intreq` = 0; `dout` reads the reset contents.
- **Combinational paths:** `dout`, `epc` and `intreq` reflect register state of the current cycle; there is no read latency.
- **mtc0 / mfc0:** an mtc0 is visible to an mfc0 one cycle later. There is no internal write-through bypass.
- **After intreq:** EPC and EXL update on the same edge that `intreq` is sampled, so `epc` is valid from the next cycle.
- **hwint:** a change shows in Cause.IP after one edge. It affects `intreq` in the same cycle, qualified by IM/IE/EXL.
- **Reset with intreq high:** reset wins and no state is captured.

## Test plan
- **Reset:** assert reset for 2 cycles, then read.
  - Expect SR = 0, Cause = 0, EPC = 0, Compare = FFFF_FFFF, PRId = 0000_4D50, intreq = 0.
- **Interrupt entry:**
  - Stimulus: mtc0 SR <= 0x0000_0401, then hwint = 6'b000001 with pcM = 0x3010, bdM = 0.
  - Expect intreq = 1. Next cycle: EPC = 0x3010, Cause = 0x0000_0400, SR.EXL = 1, and intreq = 0 even though hwint is held.
- **Exception in delay slot:**
  - Stimulus: exccodeM = 5'd10, bdM = 1, pcM = 0x3024.
  - Expect EPC = 0x3020, Cause = 0x8000_0028.
- **Priority and suppression:**
  - Stimulus: irq and exccodeM = 4 in the same cycle as we = 1 writing EPC = 0x1234.
  - Expect ExcCode = 0 and EPC = pcM; the 0x1234 write is dropped.
- **eret:**
  - Stimulus: with EXL = 1, assert eretM.
  - Expect EXL = 0 next cycle. A still-pending enabled hwint then raises intreq on that following cycle.
- **Timer:**
  - Stimulus: mtc0 Count <= 0xFFFF_FFFE, Compare <= 0x0000_0001, SR = 0x0000_8001.
  - Expect Count to wrap through 0. tpend sets on the edge where Count == 1, Cause.IP[15] = 1 follows, and intreq is asserted. An mtc0 to Compare clears tpend.
